quan_ctrl: RTL

QUAN_CTRL -- requirements
Module: quan_ctrl

---
 rtl/quan_ctrl_if.sv | 56 +++++
 rtl/quan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/quan_ctrl_if.sv
// quan_ctrl_if: groups the parameter-table write port, layer settings,
// pixel handshake, quantizer parameter outputs and status of quan_ctrl.
// The master side is the environment (host, upstream and quantizer); the
// slave side is the controller.
interface quan_ctrl_if #(
  parameter int CH_NUM = 16,
  parameter int PIX_W  = 10
);
  localparam int AW = $clog2(CH_NUM);

  // parameter-table write port
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [31:0]       cfg_m0;
  logic [7:0]        cfg_idx;
  logic [15:0]       cfg_zw;

  // layer settings and start request
  logic [7:0]        layer_z3;
  logic [AW:0]       num_ch;
  logic [PIX_W-1:0]  pix_per_ch;
  logic              start;

  // upstream pixel handshake
  logic              in_valid;
  logic              in_ready;

  // quantizer side
  logic              q_en;
  logic [31:0]       m0_scale;
  logic [7:0]        index;
  logic [15:0]       z_of_weight;
  logic [7:0]        z3;
  logic              q_valid;

  // status
  logic              busy;
  logic              done;
  logic [15:0]       out_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_m0, cfg_idx, cfg_zw,
    output layer_z3, num_ch, pix_per_ch, start,
    output in_valid, q_valid,
    input  in_ready, q_en, m0_scale, index, z_of_weight, z3,
    input  busy, done, out_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_m0, cfg_idx, cfg_zw,
    input  layer_z3, num_ch, pix_per_ch, start,
    input  in_valid, q_valid,
    output in_ready, q_en, m0_scale, index, z_of_weight, z3,
    output busy, done, out_cnt
  );
endinterface

// File: rtl/quan_ctrl.sv
// quan_ctrl: per-layer sequencer for a requantization stage. Walks the
// channels of a layer, presents each channel's quantizer parameters from a
// small table, passes pixels through while RUN, and drains the quantizer
// pipeline (QLAT cycles) before switching channel.
//
// Optional feature: define QCTRL_OUTCNT_EN to build the saturating
// quantizer-output counter on out_cnt; otherwise out_cnt is tied to 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; parameter table writable
// FETCH  | one cycle: load table entry ch_cnt into the parameter outputs
// RUN    | in_ready=1; count pixel transfers of the current channel
// SWITCH | pipeline drain, QLAT cycles, parameters held
// DONE   | one-cycle done pulse, then back to IDLE
module quan_ctrl #(
  parameter int CH_NUM = 16,
  parameter int PIX_W  = 10,
  parameter int QLAT   = 3
) (
  input  logic         clk,
  input  logic         reset,
  quan_ctrl_if.slave   bus
);
  localparam int AW = $clog2(CH_NUM);
  localparam int DW = $clog2(QLAT + 1);
  localparam logic [AW:0] CH_MAX = (AW+1)'(CH_NUM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    RUN    = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [AW:0]       nch_q, nch_d;
  logic [PIX_W-1:0]  ppc_q, ppc_d;
  logic [7:0]        z3_q, z3_d;
  logic [31:0]       m0_q, m0_d;
  logic [7:0]        idx_q, idx_d;
  logic [15:0]       zw_q, zw_d;
  logic              in_ready_c;

  // Per-channel parameter table; deliberately not reset so a configured
  // table survives an aborted layer.
  logic [31:0]       tbl_m0  [CH_NUM];
  logic [7:0]        tbl_idx [CH_NUM];
  logic [15:0]       tbl_zw  [CH_NUM];

  // Table writes are accepted only while IDLE; a write coincident with start
  // lands on the same edge, one cycle ahead of the FETCH read.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q == IDLE)) begin
      tbl_m0[bus.cfg_addr]  <= bus.cfg_m0;
      tbl_idx[bus.cfg_addr] <= bus.cfg_idx;
      tbl_zw[bus.cfg_addr]  <= bus.cfg_zw;
    end
  end

  // Next-state and datapath decode for the layer sequencer.
  always_comb begin
    state_d    = state_q;
    ch_cnt_d   = ch_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    drain_d    = drain_q;
    nch_d      = nch_q;
    ppc_d      = ppc_q;
    z3_d       = z3_q;
    m0_d       = m0_q;
    idx_d      = idx_q;
    zw_d       = zw_q;
    in_ready_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          nch_d     = (bus.num_ch > CH_MAX) ? CH_MAX : bus.num_ch;
          ppc_d     = bus.pix_per_ch;
          z3_d      = bus.layer_z3;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          drain_d   = '0;
          if ((bus.num_ch == '0) || (bus.pix_per_ch == '0)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        m0_d    = tbl_m0[ch_cnt_q];
        idx_d   = tbl_idx[ch_cnt_q];
        zw_d    = tbl_zw[ch_cnt_q];
        state_d = RUN;
      end

      RUN: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (pix_cnt_q == (ppc_q - PIX_W'(1))) begin
            pix_cnt_d = '0;
            drain_d   = DW'(QLAT);
            state_d   = SWITCH;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end

      SWITCH: begin
        // drain_q counts the remaining drain cycles including this one
        drain_d = drain_q - DW'(1);
        if (drain_q <= DW'(1)) begin
          drain_d = '0;
          if ({1'b0, ch_cnt_q} == (nch_q - (AW+1)'(1))) begin
            state_d = DONE;
          end else begin
            ch_cnt_d = ch_cnt_q + AW'(1);
            state_d  = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      drain_q   <= '0;
      nch_q     <= '0;
      ppc_q     <= '0;
      z3_q      <= '0;
      m0_q      <= '0;
      idx_q     <= '0;
      zw_q      <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      drain_q   <= drain_d;
      nch_q     <= nch_d;
      ppc_q     <= ppc_d;
      z3_q      <= z3_d;
      m0_q      <= m0_d;
      idx_q     <= idx_d;
      zw_q      <= zw_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.q_en        = bus.in_valid & in_ready_c;
  assign bus.m0_scale    = m0_q;
  assign bus.index       = idx_q;
  assign bus.z_of_weight = zw_q;
  assign bus.z3          = z3_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

`ifdef QCTRL_OUTCNT_EN
  logic [15:0] out_cnt_q, out_cnt_d;

  // Quantizer outputs seen during a layer; cleared by an accepted start.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if ((state_q == IDLE) && bus.start) begin
      out_cnt_d = '0;
    end else if ((state_q != IDLE) && bus.q_valid && (out_cnt_q != 16'hFFFF)) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end
  end

  // Output-count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.out_cnt = out_cnt_q;
`else
  logic unused_q_valid;
  assign unused_q_valid = bus.q_valid;
  assign bus.out_cnt    = '0;
`endif

endmodule
